equiv_sequencer: RTL and testbench

EQUIV_SEQUENCER -- requirements
Module: equiv_sequencer

---
 rtl/equiv_sequencer.sv | 146 ++++++++++++++
 tb/tb_equiv_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/equiv_sequencer.sv
`default_nettype none
// ============================================================================
// equiv_sequencer : drives a shared x stream into two FSMs and flags divergence
// Revision 1.0
// ============================================================================
module equiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pattern,
    input  logic [4:0]  length,
    input  logic        abort,
    input  logic        y_a,
    input  logic        y_b,
    output logic        x_out,
    output logic        fsm_reset,
    output logic        busy,
    output logic        done,
    output logic        mismatch,
    output logic [4:0]  mismatch_idx,
    output logic [4:0]  step
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] c_MAX_LEN = 5'd16;

    state_t      r_state;
    logic [15:0] r_pattern;
    logic [4:0]  r_len;
    logic [4:0]  r_step;
    logic [4:0]  r_mis_idx;
    logic        r_mis;
    logic        r_x;
    logic        r_frst;
    logic        r_busy;
    logic        r_done;

    logic [4:0]  w_len_clamped;
    logic        w_last;
    logic        w_cmp_en;
    logic [4:0]  w_cmp_idx;
    logic [3:0]  w_step_nxt;

    assign w_len_clamped = (length > c_MAX_LEN) ? c_MAX_LEN : length;
    assign w_last        = (r_step == (r_len - 5'd1));
    assign w_cmp_en      = (r_state == S_RUN) || (r_state == S_FINAL);
    // FINAL compares the state after all len inputs have been applied
    assign w_cmp_idx     = (r_state == S_FINAL) ? r_len : r_step;
    assign w_step_nxt    = r_step[3:0] + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_step    <= '0;
            r_mis_idx <= '0;
            r_mis     <= 1'b0;
            r_x       <= 1'b0;
            r_frst    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_x    <= 1'b0;
            r_frst <= 1'b0;
            r_done <= 1'b0;

            if (w_cmp_en && (y_a != y_b) && !r_mis) begin
                r_mis     <= 1'b1;
                r_mis_idx <= w_cmp_idx;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pattern <= pattern;
                        r_len     <= w_len_clamped;
                        r_mis     <= 1'b0;
                        r_mis_idx <= '0;
                        r_step    <= '0;
                        r_frst    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_RST;
                    end
                end
                S_RST: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_len != 5'd0) begin
                        r_x     <= r_pattern[0];
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_FINAL;
                    end
                end
                S_RUN: begin
                    // abort wins and leaves step at the value it had
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_step <= r_step + 5'd1;
                        r_x    <= r_pattern[w_step_nxt];
                    end
                end
                S_FINAL: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x_out        = r_x;
    assign fsm_reset    = r_frst;
    assign busy         = r_busy;
    assign done         = r_done;
    assign mismatch     = r_mis;
    assign mismatch_idx = r_mis_idx;
    assign step         = r_step;

endmodule
`default_nettype wire

// File: tb/tb_equiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_equiv_sequencer : randomized run-level checks against a timeline model
// Revision 1.0
// ============================================================================
module tb_equiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  length = '0;
    logic        abort = 1'b0;
    logic        y_a = 1'b0;
    logic        y_b = 1'b0;
    logic        x_out;
    logic        fsm_reset;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [4:0]  mismatch_idx;
    logic [4:0]  step;

    int n_checks = 0;
    int n_pass   = 0;

    equiv_sequencer u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pattern      (pattern),
        .length       (length),
        .abort        (abort),
        .y_a          (y_a),
        .y_b          (y_b),
        .x_out        (x_out),
        .fsm_reset    (fsm_reset),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx),
        .step         (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Cycle c after the accepting edge: 1 = reset pulse, 2..len+1 = inputs, len+2 = final compare
    function automatic int cmp_idx(input int c, input int len);
        return (c <= len + 1) ? c - 2 : len;
    endfunction

    function automatic int first_mm(input logic [16:0] d, input int a, input int len);
        for (int c = 2; c <= a; c++)
            if (d[cmp_idx(c, len)]) return cmp_idx(c, len);
        return -1;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_x"}, x_out, 0);
        check({tag, "_frst"}, fsm_reset, 0);
        check({tag, "_mis"}, mismatch, 0);
        check({tag, "_idx"}, mismatch_idx, 0);
        check({tag, "_step"}, step, 0);
    endtask

    task automatic run_seq(input logic [15:0] pat, input int lenin, input logic [16:0] diff,
                           input int abort_cyc, input int rst_cyc, input bit noise);
        int len;
        int last;
        int a;
        int mm;
        int exp_step;
        len = (lenin > 16) ? 16 : lenin;
        @(negedge clk);
        pattern = pat;
        length  = 5'(lenin);
        start   = 1'b1;
        abort   = 1'b0;
        @(negedge clk);
        last = (abort_cyc > 0) ? abort_cyc : len + 3;
        for (int c = 1; c <= last; c++) begin
            if (c == rst_cyc) begin
                reset = 1'b0;
                #1;
                check_reset_state("midrst");
                start = 1'b0;
                abort = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            check("busy", busy, 1);
            check("fsm_reset", fsm_reset, (c == 1) ? 1 : 0);
            check("x_out", x_out, (c >= 2 && c <= len + 1) ? 32'(pat[c-2]) : 0);
            check("done", done, (c == len + 3) ? 1 : 0);
            y_a = 1'($urandom);
            if (c >= 2 && c <= len + 2) y_b = y_a ^ diff[cmp_idx(c, len)];
            else                        y_b = 1'($urandom);
            abort = (c == abort_cyc);
            if (noise) begin
                start   = 1'($urandom);
                pattern = 16'($urandom);
                length  = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
        a  = (abort_cyc > 0) ? abort_cyc : len + 2;
        mm = first_mm(diff, a, len);
        if (abort_cyc == 1)                        exp_step = 0;
        else if (abort_cyc > 0 && abort_cyc <= len + 1) exp_step = abort_cyc - 2;
        else                                       exp_step = (len == 0) ? 0 : len - 1;
        check("end_busy", busy, 0);
        check("end_done", done, 0);
        check("end_x", x_out, 0);
        check("end_mis", mismatch, (mm >= 0) ? 1 : 0);
        check("end_idx", mismatch_idx, (mm >= 0) ? mm : 0);
        check("end_step", step, exp_step);
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_step", step, exp_step);
        check("idle_idx", mismatch_idx, (mm >= 0) ? mm : 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("idle0");

        run_seq(16'h0005, 4, 17'h0, 0, 0, 0);
        run_seq(16'($urandom), 8, 17'h28, 0, 0, 0);
        run_seq(16'($urandom), 0, 17'h0, 0, 0, 0);
        run_seq(16'($urandom), 20, 17'h0, 0, 0, 0);
        run_seq(16'($urandom), 8, 17'h0, 4, 0, 1);
        run_seq(16'hA5C3, 8, 17'h2, 0, 7, 0);
        run_seq(16'($urandom), 1, 17'h0, 0, 0, 0);

        for (int r = 0; r < 60; r++) begin
            int lenin;
            int len;
            int ab;
            logic [16:0] d;
            lenin = $urandom_range(0, 31);
            len   = (lenin > 16) ? 16 : lenin;
            ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 2) : 0;
            for (int j = 0; j < 17; j++) d[j] = ($urandom_range(0, 7) == 0);
            run_seq(16'($urandom), lenin, d, ab, 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
